// File: rtl/decoder_frame_scheduler_if.sv
// Bundle between the frame scheduler, its two requesters and the shared decoder.
// The master modport is the scheduler side; slave is the requester/decoder side.
interface decoder_frame_scheduler_if #(
   parameter int log2max_iter = 5
);
   logic [1:0]              req;
   logic [1:0]              gnt;
   logic                    dec_start;
   logic                    dec_done;
   logic                    dec_success;
   logic [log2max_iter-1:0] dec_iterations;
   logic                    res_valid;
   logic                    res_id;
   logic                    res_success;
   logic [log2max_iter-1:0] res_iterations;
   logic                    res_timeout;
   logic                    busy;
   logic [15:0]             frame_count;
   logic                    fc_load;
   logic [15:0]             fc_load_val;

   modport master (
      input  req, dec_done, dec_success, dec_iterations, fc_load, fc_load_val,
      output gnt, dec_start, res_valid, res_id, res_success, res_iterations,
             res_timeout, busy, frame_count
   );

   modport slave (
      output req, dec_done, dec_success, dec_iterations, fc_load, fc_load_val,
      input  gnt, dec_start, res_valid, res_id, res_success, res_iterations,
             res_timeout, busy, frame_count
   );
endinterface

// File: rtl/decoder_frame_scheduler.sv
// Round-robin scheduler sharing one decoder between two requesters, with a
// watchdog that aborts a run the decoder never finishes.
module decoder_frame_scheduler #(
   parameter int log2max_iter = 5,
   parameter int max_iter     = 30,
   parameter int TIMEOUT      = 4096,
   parameter int log2timeout  = 12
) (
   input  logic                             clk,
   input  logic                             rst,
   decoder_frame_scheduler_if.master        io_sched,
   output logic [1:0]                       o_dbg_state
);
   // Handshake: req is a level held by the requester until it sees its grant;
   // dec_start and res_valid are single-cycle strobes with no back-pressure,
   // and dec_done/dec_success/dec_iterations are only sampled while in WAIT.
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_REPORT} state_t;

   localparam logic [log2timeout-1:0]  WD_LAST    = log2timeout'(TIMEOUT - 1);
   localparam logic [log2max_iter-1:0] MAX_ITER_V = log2max_iter'(max_iter);

   state_t                  r_state;
   state_t                  w_next;
   logic [1:0]              r_gnt;
   logic                    r_last;
   logic [log2timeout-1:0]  r_wdog;
   logic                    r_res_id;
   logic                    r_res_success;
   logic [log2max_iter-1:0] r_res_iter;
   logic                    r_res_timeout;
   logic [15:0]             r_frame_count;
   logic                    w_win_id;
   logic                    w_expire;

   assign w_expire = (r_wdog == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (io_sched.req != 2'b00) w_next = S_START;
         S_START:  w_next = S_WAIT;
         S_WAIT:   if (io_sched.dec_done || w_expire) w_next = S_REPORT;
         S_REPORT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // On contention the requester not served last wins.
   always_comb begin
      w_win_id = io_sched.req[1];
      if (io_sched.req == 2'b11) w_win_id = ~r_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt         <= 2'b00;
         r_last        <= 1'b1;
         r_wdog        <= '0;
         r_res_id      <= 1'b0;
         r_res_success <= 1'b0;
         r_res_iter    <= '0;
         r_res_timeout <= 1'b0;
         r_frame_count <= 16'd0;
      end else begin
         if (io_sched.fc_load) r_frame_count <= io_sched.fc_load_val;
         case (r_state)
            S_IDLE: begin
               if (io_sched.req != 2'b00) r_gnt <= w_win_id ? 2'b10 : 2'b01;
            end
            S_START: r_wdog <= '0;
            S_WAIT: begin
               r_wdog <= r_wdog + 1'b1;
               // A done strobe in the expiry cycle still reports the decoder result.
               if (io_sched.dec_done) begin
                  r_res_id      <= r_gnt[1];
                  r_res_success <= io_sched.dec_success;
                  r_res_iter    <= io_sched.dec_iterations;
                  r_res_timeout <= 1'b0;
               end else if (w_expire) begin
                  r_res_id      <= r_gnt[1];
                  r_res_success <= 1'b0;
                  r_res_iter    <= MAX_ITER_V;
                  r_res_timeout <= 1'b1;
               end
            end
            S_REPORT: begin
               r_gnt         <= 2'b00;
               r_last        <= r_res_id;
               r_frame_count <= r_frame_count + 16'd1;
            end
            default: r_gnt <= 2'b00;
         endcase
      end
   end

   assign io_sched.gnt            = r_gnt;
   assign io_sched.dec_start      = (r_state == S_START);
   assign io_sched.res_valid      = (r_state == S_REPORT);
   assign io_sched.res_id         = r_res_id;
   assign io_sched.res_success    = r_res_success;
   assign io_sched.res_iterations = r_res_iter;
   assign io_sched.res_timeout    = r_res_timeout;
   assign io_sched.busy           = (r_state != S_IDLE);
   assign io_sched.frame_count    = r_frame_count;
   assign o_dbg_state             = r_state;
endmodule

// File: tb/tb_decoder_frame_scheduler.sv
// Directed bench for decoder_frame_scheduler: arbitration, latency, watchdog,
// mid-run reset and frame counter wrap, with results checked against a queue.
module tb_decoder_frame_scheduler;
   localparam int LMI  = 5;
   localparam int MAXI = 30;
   localparam int TMO  = 16;
   localparam int LTO  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [15:0] exp_frames = 16'd0;

   decoder_frame_scheduler_if #(.log2max_iter(LMI)) sif ();

   decoder_frame_scheduler #(
      .log2max_iter(LMI),
      .max_iter    (MAXI),
      .TIMEOUT     (TMO),
      .log2timeout (LTO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .io_sched   (sif.master),
      .o_dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=stuck expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] res_word();
      return {sif.res_id, sif.res_success, sif.res_iterations, sif.res_timeout};
   endfunction

   // driver: one complete run; delay <= 0 means the decoder never answers
   task automatic do_run(input logic [1:0] rq, input logic exp_id, input int delay,
                         input logic succ, input logic [LMI-1:0] it, input bit drop_req);
      logic [1:0] exp_gnt;
      logic [7:0] exp_res;
      logic [7:0] held;
      int         exp_lat;
      bit         seen;
      exp_gnt = exp_id ? 2'b10 : 2'b01;
      sif.req = rq;
      tick();
      check("start_pulse", sif.dec_start, 1);
      check("start_gnt", sif.gnt, exp_gnt);
      if (delay > 0) begin
         exp_res = {exp_id, succ, it, 1'b0};
         exp_lat = delay + 1;
      end else begin
         exp_res = {exp_id, 1'b0, LMI'(MAXI), 1'b1};
         exp_lat = TMO + 1;
      end
      exp_q.push_back(exp_res);
      if (drop_req) sif.req = 2'b00;
      seen = 0;
      for (int n = 1; n <= TMO + 20; n++) begin
         tick();
         if (sif.res_valid) begin
            seen = 1;
            check("latency", n, exp_lat);
            check("result", res_word(), exp_q.pop_front());
            check("report_gnt", sif.gnt, exp_gnt);
            break;
         end
         check("wait_hold", {sif.dec_start, sif.gnt}, {1'b0, exp_gnt});
         sif.dec_done = (n == delay);
         if (n == delay) begin
            sif.dec_success    = succ;
            sif.dec_iterations = it;
         end else begin
            sif.dec_success    = 1'($urandom_range(0, 1));
            sif.dec_iterations = LMI'($urandom_range(0, 31));
         end
      end
      check("result_seen", seen, 1);
      sif.dec_done = 1'b0;
      held = res_word();
      exp_frames = exp_frames + 16'd1;
      tick();
      check("post_idle", {sif.gnt, sif.busy, sif.res_valid}, 4'b0000);
      check("frame_count", sif.frame_count, exp_frames);
      check("res_hold", res_word(), held);
   endtask

   initial begin
      sif.req            = 2'b00;
      sif.dec_done       = 1'b0;
      sif.dec_success    = 1'b0;
      sif.dec_iterations = '0;
      sif.fc_load        = 1'b0;
      sif.fc_load_val    = 16'd0;
      tick();
      tick();
      check("reset_outputs",
            {sif.gnt, sif.dec_start, sif.res_valid, sif.res_id, sif.res_success,
             sif.res_iterations, sif.res_timeout, sif.busy, sif.frame_count}, 0);
      check("reset_state", dbg_state, 0);
      rst = 1'b0;

      // single requester, decoder answers three cycles after dec_start
      do_run(2'b01, 1'b0, 3, 1'b1, 5'd7, 1'b0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_frames = 16'd0;

      // contention alternates starting with requester 0
      do_run(2'b11, 1'b0, $urandom_range(1, 10), 1'($urandom_range(0, 1)), LMI'($urandom_range(0, 31)), 1'b0);
      do_run(2'b11, 1'b1, $urandom_range(1, 10), 1'($urandom_range(0, 1)), LMI'($urandom_range(0, 31)), 1'b0);
      do_run(2'b11, 1'b0, $urandom_range(1, 10), 1'($urandom_range(0, 1)), LMI'($urandom_range(0, 31)), 1'b0);
      do_run(2'b11, 1'b1, $urandom_range(1, 10), 1'($urandom_range(0, 1)), LMI'($urandom_range(0, 31)), 1'b0);
      check("four_runs_count", sif.frame_count, 16'd4);

      // watchdog expiry, then done landing exactly on the expiry cycle with req dropped
      do_run(2'b10, 1'b1, 0, 1'b0, 5'd0, 1'b0);
      do_run(2'b01, 1'b0, TMO, 1'b1, 5'd19, 1'b1);

      // mid-run reset: pointer now favours requester 1
      sif.req = 2'b11;
      tick();
      check("mr_gnt", sif.gnt, 2'b10);
      tick();
      tick();
      tick();
      check("mr_in_wait", dbg_state, 2'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_frames = 16'd0;
      check("mr_outputs",
            {sif.gnt, sif.dec_start, sif.res_valid, sif.res_id, sif.res_success,
             sif.res_iterations, sif.res_timeout, sif.busy, sif.frame_count}, 0);
      check("mr_state", dbg_state, 0);
      do_run(2'b11, 1'b0, 4, 1'b0, 5'd12, 1'b0);

      // stray done while idle
      sif.req         = 2'b00;
      sif.dec_done    = 1'b1;
      sif.dec_success = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("idle_done", {sif.busy, sif.res_valid, sif.dec_start}, 3'b000);
         check("idle_done_count", sif.frame_count, exp_frames);
      end
      sif.dec_done = 1'b0;

      // counter wrap
      sif.fc_load     = 1'b1;
      sif.fc_load_val = 16'hFFFF;
      tick();
      sif.fc_load = 1'b0;
      check("fc_preload", sif.frame_count, 16'hFFFF);
      exp_frames = 16'hFFFF;
      do_run(2'b10, 1'b1, 2, 1'b1, 5'd3, 1'b0);
      check("fc_wrap", sif.frame_count, 16'd0);

      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/decoder_frame_scheduler.md
DECODER_FRAME_SCHEDULER -- requirements
Module: decoder_frame_scheduler

Interface
REQ-001 Parameter: log2max_iter, default 5, width of the iteration count.
REQ-002 Parameter: max_iter, default 30, value reported as the iteration count on timeout.
REQ-003 Parameter: TIMEOUT, default 4096, cycles in WAIT before a run is aborted.
REQ-004 Parameter: log2timeout, default 12, width of the watchdog counter.
REQ-005 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-006 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 Port: rst  input  1  synchronous, active-high reset.
REQ-008 Port: req  input  2  level request per requester (bit i = requester i) to decode one frame.
REQ-009 Port: gnt  output  2  one-hot grant; selects whose frame feeds the decoder.
REQ-010 Port: dec_start  output  1  one-cycle pulse that starts the shared decoder.
REQ-011 Port: dec_done  input  1  decoder-finished strobe.
REQ-012 Port: dec_success  input  1  decoder syndrome-check result, valid with dec_done.
REQ-013 Port: dec_iterations  input  log2max_iter  iterations used, valid with dec_done.
REQ-014 Port: res_valid  output  1  one-cycle result strobe.
REQ-015 Port: res_id  output  1  requester index of the reported result.
REQ-016 Port: res_success  output  1  captured success flag.
REQ-017 Port: res_iterations  output  log2max_iter  captured iteration count.
REQ-018 Port: res_timeout  output  1  run aborted by the watchdog.
REQ-019 Port: busy  output  1  high in every state except IDLE.
REQ-020 Port: frame_count  output  16  number of completed runs, wraps at 65535 -> 0.

Function
REQ-021 The FSM SHALL have states IDLE, START, WAIT and REPORT.
REQ-022 IDLE: with req != 0, the block SHALL select a winner, register gnt and go to START on the next edge; with req == 0 it SHALL stay in IDLE and hold gnt = 0.
REQ-023 Arbitration SHALL be round-robin: if both bits of req are set, the requester not served last wins; otherwise the single requester wins.
REQ-024 The last-served pointer SHALL reset to 1, so requester 0 wins the first contention after reset.
REQ-025 START SHALL last exactly 1 cycle, with dec_start = 1 and the watchdog cleared; the next state is WAIT.
REQ-026 gnt SHALL stay constant from START through REPORT inclusive.
REQ-027 Deasserting req after the grant SHALL NOT abort the run.
REQ-028 A dec_done asserted during START or IDLE SHALL be ignored.
REQ-029 WAIT: the watchdog SHALL increment by 1 per cycle.
REQ-030 WAIT: on dec_done = 1, the block SHALL capture dec_success and dec_iterations, set timeout = 0 and go to REPORT.
REQ-031 WAIT: if dec_done = 0 while the watchdog equals TIMEOUT-1, the block SHALL capture success = 0, iterations = max_iter, timeout = 1 and go to REPORT.
REQ-032 If dec_done arrives in the same cycle as the watchdog expiry, dec_done SHALL win.
REQ-033 REPORT SHALL last 1 cycle: res_valid = 1 with res_id, res_success, res_iterations and res_timeout; frame_count increments; the last-served pointer updates; the next state is IDLE.
REQ-034 gnt SHALL be 0 in the cycle after REPORT, so there are at least 2 idle cycles of the decoder between runs.
REQ-035 The res_* data outputs SHALL hold their values until the next REPORT.
REQ-036 Latency SHALL be: req asserted at cycle 0 -> dec_start at cycle 1 -> dec_done at cycle k (k >= 2) -> res_valid at cycle k+1.

Reset
REQ-037 With rst = 1, on the next edge the FSM SHALL go to IDLE; gnt, dec_start, res_valid, res_id, res_success, res_iterations, res_timeout, busy, frame_count and the watchdog SHALL clear to 0, and the pointer SHALL be set to 1.
REQ-038 Reset SHALL take priority over every other event, including in mid-run (START or WAIT).
REQ-039 An aborted run SHALL produce no res_valid.

Verification
REQ-040 Hold req = 01, return dec_done with success = 1 and iterations = 7 three cycles after dec_start -> gnt = 01, exactly one dec_start, res_valid one cycle later with id 0, success 1, iterations 7, timeout 0, frame_count 1.
REQ-041 Hold req = 11 for 4 runs -> grants in the order 0, 1, 0, 1 and frame_count = 4.
REQ-042 Never assert dec_done, with TIMEOUT = 16 -> res_valid exactly 17 cycles after dec_start, with success 0, iterations 30, timeout 1.
REQ-043 Assert dec_done in the cycle the watchdog reaches TIMEOUT-1 -> timeout 0 and the decoder's values are reported.
REQ-044 Assert rst in the 3rd WAIT cycle -> next cycle all outputs are 0, no res_valid, and a subsequent req = 11 grants requester 0.
REQ-045 Preload frame_count = 65535, complete one run -> frame_count = 0; a dec_done pulse while in IDLE has no effect.
